// File: rtl/rs_alu_bank_if.sv
// rs_alu_bank_if
//   Issue port, snooped CDB input, CDB output handshake and status outputs of
//   the integer-ALU reservation-station bank, bundled into one interface.
//
//   Issue port     : issue, opcode[2:0], A, B, A_invalid, B_invalid
//   CDB snoop in   : cdb_write_in, cdb_source_in, cdb_data_in
//   CDB handshake  : cdb_xmit (grant in), cdb_rts, cdb_write, cdb_source, cdb_data
//   Status         : available, issued, rs_executing, error
//
//   slave  modport : the bank (consumes issue/snoop/grant, drives everything else)
//   master modport : the issuing / arbitrating environment
interface rs_alu_bank_if #(
   parameter int DATA_W = 32,
   parameter int TAG_W  = 6
);
   logic              issue;
   logic [2:0]        opcode;
   logic [DATA_W-1:0] A;
   logic [DATA_W-1:0] B;
   logic              A_invalid;
   logic              B_invalid;

   logic              cdb_write_in;
   logic [TAG_W-1:0]  cdb_source_in;
   logic [DATA_W-1:0] cdb_data_in;
   logic              cdb_xmit;

   logic              cdb_rts;
   logic              cdb_write;
   logic [TAG_W-1:0]  cdb_source;
   logic [DATA_W-1:0] cdb_data;
   logic              available;
   logic [TAG_W-1:0]  issued;
   logic [TAG_W-1:0]  rs_executing;
   logic              error;

   modport slave (
      input  issue, opcode, A, B, A_invalid, B_invalid,
      input  cdb_write_in, cdb_source_in, cdb_data_in, cdb_xmit,
      output cdb_rts, cdb_write, cdb_source, cdb_data,
      output available, issued, rs_executing, error
   );

   modport master (
      output issue, opcode, A, B, A_invalid, B_invalid,
      output cdb_write_in, cdb_source_in, cdb_data_in, cdb_xmit,
      input  cdb_rts, cdb_write, cdb_source, cdb_data,
      input  available, issued, rs_executing, error
   );
endinterface

// File: rtl/rs_alu_bank.sv
// rs_alu_bank
//   Integer-ALU reservation-station bank for a Tomasulo datapath. NUM_RS
//   stations hold issued operations, capture missing operands from the CDB,
//   and are dispatched one at a time (round-robin from ptr) into a single
//   LATENCY-cycle ALU whose result is broadcast under an rts/xmit handshake.
//
//   Ports:
//     clock  : sole clock, all state on the rising edge
//     reset  : synchronous, active-high
//     bus    : rs_alu_bank_if.slave (issue port, CDB snoop, CDB output, status)
//
//   Parameters: DATA_W, TAG_W, NUM_RS (2..8), BASE_TAG (tag of station 0),
//               LATENCY (>=1, cycles from dispatch to result ready).
//
//   Optional feature macro: RS_ISSUE_BYPASS_EN
//     defined   : an invalid operand whose tag is being broadcast on the issue
//                 edge is captured directly from cdb_data_in.
//     undefined : such an issue is refused silently (issued=0, error=0) and
//                 the issuer retries.
module rs_alu_bank #(
   parameter int DATA_W   = 32,
   parameter int TAG_W    = 6,
   parameter int NUM_RS   = 3,
   parameter int BASE_TAG = 1,
   parameter int LATENCY  = 2
) (
   input logic          clock,
   input logic          reset,
   rs_alu_bank_if.slave bus
);
   localparam int IDX_W = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;
   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

   // station storage
   logic [NUM_RS-1:0] busy_q, busy_d;
   logic [2:0]        op_q [NUM_RS];
   logic [2:0]        op_d [NUM_RS];
   logic [TAG_W-1:0]  qj_q [NUM_RS];
   logic [TAG_W-1:0]  qj_d [NUM_RS];
   logic [TAG_W-1:0]  qk_q [NUM_RS];
   logic [TAG_W-1:0]  qk_d [NUM_RS];
   logic [DATA_W-1:0] vj_q [NUM_RS];
   logic [DATA_W-1:0] vj_d [NUM_RS];
   logic [DATA_W-1:0] vk_q [NUM_RS];
   logic [DATA_W-1:0] vk_d [NUM_RS];

   // dispatch / execute state
   state_t            state_q, state_d;
   logic [IDX_W-1:0]  ptr_q, ptr_d;
   logic [IDX_W-1:0]  ex_idx_q, ex_idx_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [2:0]        ex_op_q, ex_op_d;
   logic [DATA_W-1:0] ex_a_q, ex_a_d;
   logic [DATA_W-1:0] ex_b_q, ex_b_d;
   logic [DATA_W-1:0] res_q, res_d;

   // registered status pulses
   logic [TAG_W-1:0]  issued_q, issued_d;
   logic              error_q, error_d;

   // selection / issue decode
   logic [NUM_RS-1:0] ready;
   logic              free_found, rdy_found;
   logic [IDX_W-1:0]  free_idx, rdy_idx;
   logic              illegal_op, a_hit, b_hit, a_byp, b_byp;
   logic              issue_hold, issue_ok, issue_err;
   logic              ex_last, grant;

   function automatic logic [TAG_W-1:0] tag_of(input logic [IDX_W-1:0] idx);
      return TAG_W'(BASE_TAG + int'(idx));
   endfunction

   // Station index 'off' positions after 'base', wrapping at NUM_RS.
   function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= NUM_RS) s = s - NUM_RS;
      return IDX_W'(s);
   endfunction

   function automatic logic [DATA_W-1:0] alu_f(input logic [2:0] op,
                                               input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
      logic [DATA_W-1:0] r;
      case (op)
         3'b000:  r = a + b;
         3'b001:  r = a - b;
         3'b100:  r = a | b;
         3'b101:  r = a & b;
         3'b110:  r = ~a;
         3'b111:  r = a ^ b;
         default: r = '0;
      endcase
      return r;
   endfunction

   always_comb begin
      for (int i = 0; i < NUM_RS; i++)
         ready[i] = busy_q[i] && (qj_q[i] == '0) && (qk_q[i] == '0);
   end

   // Round-robin search from ptr for both the issue target and the dispatch candidate.
   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      rdy_found  = 1'b0;
      rdy_idx    = '0;
      for (int i = 0; i < NUM_RS; i++) begin
         if (!free_found && !busy_q[rr_idx(ptr_q, i)]) begin
            free_found = 1'b1;
            free_idx   = rr_idx(ptr_q, i);
         end
         if (!rdy_found && ready[rr_idx(ptr_q, i)]) begin
            rdy_found = 1'b1;
            rdy_idx   = rr_idx(ptr_q, i);
         end
      end
   end

   // A new station is not yet busy, so the same-edge snoop cannot reach it;
   // an operand whose producer is broadcasting right now needs special handling.
   assign illegal_op = (bus.opcode == 3'b010) || (bus.opcode == 3'b011);
   assign a_hit = bus.cdb_write_in && (bus.cdb_source_in != '0) && bus.A_invalid &&
                  (bus.A[TAG_W-1:0] == bus.cdb_source_in);
   assign b_hit = bus.cdb_write_in && (bus.cdb_source_in != '0) && bus.B_invalid &&
                  (bus.B[TAG_W-1:0] == bus.cdb_source_in);

`ifdef RS_ISSUE_BYPASS_EN
   assign issue_hold = 1'b0;
   assign a_byp      = a_hit;
   assign b_byp      = b_hit;
`else
   assign issue_hold = a_hit || b_hit;
   assign a_byp      = 1'b0;
   assign b_byp      = 1'b0;
`endif

   assign issue_err = bus.issue && (illegal_op || !free_found);
   assign issue_ok  = bus.issue && !illegal_op && free_found && !issue_hold;
   assign ex_last   = (cnt_q == CNT_W'(LATENCY - 1));
   assign grant     = (state_q == S_DONE) && bus.cdb_xmit;

   // station next state: snoop, free on grant, then load the issued station
   always_comb begin
      busy_d = busy_q;
      op_d   = op_q;
      qj_d   = qj_q;
      qk_d   = qk_q;
      vj_d   = vj_q;
      vk_d   = vk_q;

      if (bus.cdb_write_in && (bus.cdb_source_in != '0)) begin
         for (int i = 0; i < NUM_RS; i++) begin
            if (busy_q[i] && (qj_q[i] == bus.cdb_source_in)) begin
               vj_d[i] = bus.cdb_data_in;
               qj_d[i] = '0;
            end
            if (busy_q[i] && (qk_q[i] == bus.cdb_source_in)) begin
               vk_d[i] = bus.cdb_data_in;
               qk_d[i] = '0;
            end
         end
      end

      if (grant) busy_d[ex_idx_q] = 1'b0;

      if (issue_ok) begin
         busy_d[free_idx] = 1'b1;
         op_d[free_idx]   = bus.opcode;
         qj_d[free_idx]   = (bus.A_invalid && !a_byp) ? bus.A[TAG_W-1:0] : '0;
         vj_d[free_idx]   = a_byp ? bus.cdb_data_in : bus.A;
         qk_d[free_idx]   = (bus.B_invalid && !b_byp) ? bus.B[TAG_W-1:0] : '0;
         vk_d[free_idx]   = b_byp ? bus.cdb_data_in : bus.B;
      end

      issued_d = issue_ok ? tag_of(free_idx) : '0;
      error_d  = issue_err;
   end

   // dispatch FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (rdy_found) state_d = S_EXEC;
         S_EXEC:  if (ex_last) state_d = S_DONE;
         S_DONE:  if (bus.cdb_xmit) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // execute datapath next state
   always_comb begin
      ptr_d    = ptr_q;
      ex_idx_d = ex_idx_q;
      cnt_d    = cnt_q;
      ex_op_d  = ex_op_q;
      ex_a_d   = ex_a_q;
      ex_b_d   = ex_b_q;
      res_d    = res_q;
      case (state_q)
         S_IDLE: begin
            if (rdy_found) begin
               ex_idx_d = rdy_idx;
               ex_op_d  = op_q[rdy_idx];
               ex_a_d   = vj_q[rdy_idx];
               ex_b_d   = vk_q[rdy_idx];
               cnt_d    = '0;
            end
         end
         S_EXEC: begin
            cnt_d = cnt_q + 1'b1;
            if (ex_last) res_d = alu_f(ex_op_q, ex_a_q, ex_b_q);
         end
         S_DONE: begin
            if (bus.cdb_xmit) ptr_d = rr_idx(ex_idx_q, 1);
         end
         default: ;
      endcase
   end

   // control registers
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= S_IDLE;
         busy_q   <= '0;
         ptr_q    <= '0;
         ex_idx_q <= '0;
         cnt_q    <= '0;
         issued_q <= '0;
         error_q  <= 1'b0;
         for (int i = 0; i < NUM_RS; i++) begin
            qj_q[i] <= '0;
            qk_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         busy_q   <= busy_d;
         ptr_q    <= ptr_d;
         ex_idx_q <= ex_idx_d;
         cnt_q    <= cnt_d;
         issued_q <= issued_d;
         error_q  <= error_d;
         qj_q     <= qj_d;
         qk_q     <= qk_d;
      end
   end

   // data registers: only ever observed behind busy/state qualifiers
   always_ff @(posedge clock) begin
      op_q    <= op_d;
      vj_q    <= vj_d;
      vk_q    <= vk_d;
      ex_op_q <= ex_op_d;
      ex_a_q  <= ex_a_d;
      ex_b_q  <= ex_b_d;
      res_q   <= res_d;
   end

   // dispatch FSM: outputs
   always_comb begin
      bus.cdb_rts      = (state_q == S_DONE);
      bus.cdb_write    = grant;
      bus.cdb_source   = grant ? tag_of(ex_idx_q) : '0;
      bus.cdb_data     = grant ? res_q : '0;
      bus.rs_executing = (state_q != S_IDLE) ? tag_of(ex_idx_q) : '0;
      bus.available    = ~&busy_q;
      bus.issued       = issued_q;
      bus.error        = error_q;
   end
endmodule

// File: doc/rs_alu_bank.md
# rs_alu_bank

Parametrised integer-ALU reservation-station bank for the Tomasulo datapath. Holds NUM_RS issued operations, captures missing operands by snooping the common data bus (CDB), dispatches one ready station at a time in round-robin order to a single LATENCY-cycle ALU, and broadcasts the result on the CDB under an rts/xmit handshake with the bus arbiter. Generalises the fixed three-station adder unit in station count, data/tag width and execution latency, and adds reset, illegal-opcode detection and fair selection.

## Interface
- DATA_W, 32, operand/result width
- TAG_W, 6, RS tag width; tag 0 means "value valid / no source"
- NUM_RS, 3, number of stations (2..8)
- BASE_TAG, 1, tag of station 0; station i has tag BASE_TAG+i
- LATENCY, 2, ALU cycles from dispatch to result ready (>=1)

- clock  in  1  sole clock, all state on rising edge
- reset  in  1  synchronous, active-high
- issue  in  1  issue request this cycle
- opcode  in  3  000 add, 001 sub, 100 or, 101 and, 110 not, 111 xor
- A, B  in  DATA_W  operand value, or producer tag in [TAG_W-1:0] when invalid
- A_invalid, B_invalid  in  1  operand is a pending tag
- cdb_write_in, cdb_source_in[TAG_W], cdb_data_in[DATA_W]  in  snooped CDB broadcast
- cdb_xmit  in  1  arbiter grant
- cdb_rts  out  1  result waiting for bus
- cdb_write  out  1  = cdb_rts & cdb_xmit
- cdb_source  out  TAG_W  executing station tag when cdb_write, else 0
- cdb_data  out  DATA_W  result when cdb_write, else 0
- available  out  1  at least one station free
- issued  out  TAG_W  one-cycle pulse: tag of station accepting the issue, else 0
- rs_executing  out  TAG_W  tag of station owning the ALU, else 0
- error  out  1  one-cycle pulse: issue rejected

## Operation
- Station state: busy, op, Qj/Qk (TAG_W), Vj/Vk (DATA_W). Ready = busy & Qj==0 & Qk==0.
- Priority pointer ptr (0..NUM_RS-1); search order ptr, ptr+1, ... modulo NUM_RS, for both issue and dispatch.
- Issue: on edge with issue=1, first free station in search order is loaded; invalid operand stores Qx=A/B[TAG_W-1:0], valid stores Vx, Qx=0; issued=its tag. No free station, or opcode 010/011: no state change, error=1, issued=0.
- Snoop: on edge with cdb_write_in, every busy station with Qj (Qk) == cdb_source_in != 0 loads Vj (Vk) and clears the tag. Includes this bank's own broadcasts.
- Dispatch FSM: IDLE -> EXEC (first ready station in search order; latch op/Vj/Vk, rs_executing=tag) -> after LATENCY cycles DONE (result registered, cdb_rts=1) -> on edge with cdb_xmit=1: station freed, ptr = executing index+1 mod NUM_RS, back to IDLE.
- Arithmetic modulo 2^DATA_W, no overflow flag; not ignores Vk.

## Timing
- Reset: all stations free, ptr=0, FSM IDLE, every output 0 (available=1). Reset mid-EXEC/DONE discards the result; cdb_rts falls next cycle.
- issued/error valid the cycle after the issue edge.
- Dispatch earliest the edge after the station becomes ready; cdb_rts high LATENCY cycles after dispatch edge; held until granted.
- cdb_xmit without cdb_rts ignored. Grant edge: cdb_rts low next cycle; station free (available) next cycle; new dispatch earliest the cycle after return to IDLE.
- A station freed on an edge cannot be issued on that same edge.
- Issue and snoop on same edge for different stations: both take effect.

## Configuration
- RS_ISSUE_BYPASS_EN defined: on an issue edge where cdb_write_in=1 and an invalid operand tag equals cdb_source_in, that operand is stored as Vx=cdb_data_in, Qx=0.
- Not defined: such an issue is refused (issued=0, error=0, no state change); issuer retries next cycle.

## Test plan
- Reset, issue add A=5,B=7 both valid -> issued=1; LATENCY+1 cycles later cdb_rts=1; xmit -> cdb_write=1, cdb_source=1, cdb_data=12.
- Issue sub with A tag 9 invalid, B=3; broadcast tag 9 data 10 -> result 7 from station 1; unrelated tag 8 broadcast leaves it waiting.
- Fill all 3 stations then 4th issue -> error=1, available=0; grant one result -> available=1 next cycle, retry accepted.
- Three ready stations, grant each immediately -> dispatch order 1,2,3 then ptr wraps to station 1.
- Issue opcode 010 -> error=1, issued=0; 0x7FFFFFFF+1 -> 0x80000000.
- Issue with A tag 4 coinciding with tag-4 broadcast of 20: with RS_ISSUE_BYPASS_EN issued=1 and operand valid; without, issued=0, accepted on retry.
